osc_bank_sequencer: RTL and testbench

Time-multiplexed controller for a bank of second-order recursive sine oscillators, y[n] = 2·cos(w)·y[n-1] − y[n-2], sharing one 16×16 signed multiplier.
- Generates the 48 kHz sample tick from the system clock.
- On each tick, steps through every enabled channel: loads its state, runs the multiply, updates the recurrence and presents the sample on a valid/ready output.
- Sits between the configuration register file (per-channel coefficient and initial value) and the downstream audio mixer.

---
 rtl/osc_bank_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_osc_bank_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_bank_sequencer.sv
// Purpose: time-multiplexed bank of recursive sine oscillators y[n] = 2cos(w)y[n-1] - y[n-2] sharing one 16x16 multiplier.
// Latency: k-th enabled channel presents its sample at tick+4+4k (LOAD, MUL, ACC, OUT per channel).
// Backpressure: out_valid/out_ready; OUT holds out_ch/out_data stable until accepted, each stall cycle delays the sequence.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   ch_en               per-channel enable, latched on sample_tick
//   cfg_we/ch/cos/init  configuration write (accepted only while cfg_ready)
//   cfg_ready           high in IDLE
//   sample_tick         one-cycle pulse every SYSTEM_FREQUENCY/SAMPLING_FREQUENCY clocks
//   out_valid/ready/ch/data  sample stream to the mixer
//   overrun             sticky: tick arrived while the bank was still busy
//   sat_flag            sticky clamp indicator
// Optional feature: define OSC_SATURATE_EN to clamp the recurrence to 16 bits
// and drive sat_flag; otherwise the result wraps and sat_flag is tied low.
module osc_bank_sequencer #(
    parameter int SYSTEM_FREQUENCY   = 50000000,
    parameter int SAMPLING_FREQUENCY = 48000,
    parameter int NUM_CH             = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]   cfg_ch,
    input  logic [15:0]                 cfg_cos,
    input  logic [15:0]                 cfg_init,
    output logic                        cfg_ready,
    output logic                        sample_tick,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NUM_CH)-1:0]   out_ch,
    output logic [15:0]                 out_data,
    output logic                        overrun,
    output logic                        sat_flag
);
    localparam int CW          = $clog2(NUM_CH);
    localparam int CLOCK_TICKS = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
    localparam int TW          = $clog2(CLOCK_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLOCK_TICKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_ACC, S_OUT} state_t;

    state_t              state;
    logic [TW-1:0]       tick_cnt;
    logic [NUM_CH-1:0]   en_mask;
    logic [NUM_CH-1:0]   rest_mask;
    logic [CW-1:0]       cur;

    logic signed [15:0]  cos_mem [NUM_CH];
    logic signed [15:0]  y1_mem  [NUM_CH];
    logic signed [15:0]  y2_mem  [NUM_CH];

    logic signed [15:0]  op_cos;
    logic signed [15:0]  op_y1;
    logic signed [15:0]  op_y2;
    logic signed [31:0]  prod;
    logic signed [17:0]  p_r;       // prod[31:14] == 2*cos*y1 in Q1.15, 18 bits wide
    logic signed [17:0]  acc_sum;
    logic signed [15:0]  acc_res;
    logic                acc_clip;
    logic                unused_bits;

    // Lowest-index set bit; callers only use it on a non-zero mask.
    function automatic logic [CW-1:0] lowest(input logic [NUM_CH-1:0] m);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) idx = CW'(i);
        end
        return idx;
    endfunction

    assign sample_tick = (tick_cnt == TICK_LAST);
    assign cfg_ready   = (state == S_IDLE);
    assign rest_mask   = en_mask & ~(NUM_CH'(1) << cur);

    assign prod    = 32'(op_y1) * 32'(op_cos);
    // Range of p_r is about +/-65536 and y2 is 16 bits, so 18 bits cannot overflow.
    assign acc_sum = p_r - 18'(op_y2);

    always_comb begin
        acc_res  = acc_sum[15:0];
        acc_clip = 1'b0;
`ifdef OSC_SATURATE_EN
        if (acc_sum > 18'sd32767) begin
            acc_res  = 16'sh7FFF;
            acc_clip = 1'b1;
        end else if (acc_sum < -18'sd32768) begin
            acc_res  = -16'sh8000;
            acc_clip = 1'b1;
        end
`endif
    end

`ifdef OSC_SATURATE_EN
    logic sat_r;
    assign sat_flag    = sat_r;
    assign unused_bits = ^{prod[13:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_r <= 1'b0;
        end else if (state == S_ACC && acc_clip) begin
            sat_r <= 1'b1;
        end
    end
`else
    assign sat_flag    = 1'b0;
    assign unused_bits = ^{prod[13:0], acc_sum[17:16], acc_clip};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (sample_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            en_mask   <= '0;
            cur       <= '0;
            op_cos    <= '0;
            op_y1     <= '0;
            op_y2     <= '0;
            p_r       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cos_mem[i] <= '0;
                y1_mem[i]  <= '0;
                y2_mem[i]  <= '0;
            end
        end else begin
            // A tick while busy is dropped; the current sweep runs to completion.
            if (sample_tick && state != S_IDLE) overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (cfg_ch == CW'(i)) begin
                                cos_mem[i] <= cfg_cos;
                                y1_mem[i]  <= cfg_init;
                                y2_mem[i]  <= '0;
                            end
                        end
                    end
                    if (sample_tick && |ch_en) begin
                        en_mask <= ch_en;
                        cur     <= lowest(ch_en);
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    op_cos <= cos_mem[cur];
                    op_y1  <= y1_mem[cur];
                    op_y2  <= y2_mem[cur];
                    state  <= S_MUL;
                end
                S_MUL: begin
                    p_r   <= prod[31:14];
                    state <= S_ACC;
                end
                S_ACC: begin
                    y2_mem[cur] <= op_y1;
                    y1_mem[cur] <= acc_res;
                    out_data    <= acc_res;
                    out_ch      <= cur;
                    out_valid   <= 1'b1;
                    state       <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (|rest_mask) begin
                            en_mask <= rest_mask;
                            cur     <= lowest(rest_mask);
                            state   <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_osc_bank_sequencer.sv
// Purpose: directed self-checking bench for osc_bank_sequencer (default parameters).
// Latency: samples checked exactly at tick+4+4k, with out_valid low in the cycles around them.
// Backpressure: a long out_ready stall exercises hold, overrun and discarded config writes.
module tb_osc_bank_sequencer;
    localparam int NUM_CH = 4;
`ifdef OSC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [15:0]       cfg_cos;
    logic [15:0]       cfg_init;
    logic              cfg_ready;
    logic              sample_tick;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_ch;
    logic [15:0]       out_data;
    logic              overrun;
    logic              sat_flag;

    int errors = 0;
    int checks = 0;

    osc_bank_sequencer #(
        .SYSTEM_FREQUENCY  (50000000),
        .SAMPLING_FREQUENCY(48000),
        .NUM_CH            (NUM_CH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_en      (ch_en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_cos    (cfg_cos),
        .cfg_init   (cfg_init),
        .cfg_ready  (cfg_ready),
        .sample_tick(sample_tick),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_data   (out_data),
        .overrun    (overrun),
        .sat_flag   (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] cos;
        logic [15:0] init;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] c, input logic [15:0] i);
        cfg_ch   = ch;
        cfg_cos  = c;
        cfg_init = i;
        cfg_we   = 1'b1;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Leaves the bench at the negedge of the tick cycle T.
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (sample_tick) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tick_timeout: got no tick expected tick within 1100 cycles");
        end
    endtask

    function automatic logic [15:0] osc_model(input logic signed [15:0] c,
                                              input logic signed [15:0] y1,
                                              input logic signed [15:0] y2);
        int p;
        int s;
        p = int'(c) * int'(y1);
        s = (p >>> 14) - int'(y2);
`ifdef OSC_SATURATE_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    initial begin
        bit ok;
        int ticks_seen;
        int last_tick;
        int bad_cnt;
        bit seen_tick;
        logic signed [15:0] m_y1;
        logic signed [15:0] m_y2;
        logic [15:0] m_exp;

        vecs[0] = '{2'd0, 16'h7EE8, 16'h10B5, 16'h2120};
        vecs[1] = '{2'd1, 16'h4000, 16'h2000, 16'h2000};
        vecs[2] = '{2'd2, 16'h0000, 16'h1234, 16'h0000};
        vecs[3] = '{2'd3, 16'hC000, 16'h2000, 16'hE000};
        vecs[4] = '{2'd0, 16'h8000, 16'h4000, 16'h8000};

        reset     = 1'b1;
        ch_en     = '0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_cos   = '0;
        cfg_init  = '0;
        out_ready = 1'b1;
        step(3);

        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_sample_tick", sample_tick, 0);
        reset = 1'b0;

        // Idle time base: three ticks, spaced 1041 cycles, nothing else moves.
        ticks_seen = 0;
        last_tick  = 0;
        bad_cnt    = 0;
        for (int c = 0; c < 3 * 1041 + 5; c++) begin
            step(1);
            if (out_valid || overrun) bad_cnt++;
            if (sample_tick) begin
                if (ticks_seen > 0) chk("tick_period", c - last_tick, 1041);
                last_tick = c;
                ticks_seen++;
            end
        end
        chk("idle_tick_count", ticks_seen, 3);
        chk("idle_quiet_cycles", bad_cnt, 0);

        // Single-channel vectors: exact latency and first-sample value.
        for (int v = 0; v < 5; v++) begin
            cfg_write(vecs[v].ch, vecs[v].cos, vecs[v].init);
            ch_en = NUM_CH'(1) << vecs[v].ch;
            wait_tick(ok);
            if (ok) begin
                step(1);
                chk($sformatf("v%0d_cfg_ready_T1", v), cfg_ready, 0);
                step(2);
                chk($sformatf("v%0d_valid_T3", v), out_valid, 0);
                step(1);
                chk($sformatf("v%0d_valid_T4", v), out_valid, 1);
                chk($sformatf("v%0d_ch", v), out_ch, vecs[v].ch);
                chk($sformatf("v%0d_data", v), out_data, vecs[v].exp);
                step(1);
                chk($sformatf("v%0d_valid_T5", v), out_valid, 0);
                chk($sformatf("v%0d_cfg_ready_T5", v), cfg_ready, 1);
            end
            ch_en = '0;
        end

        // Recurrence over several ticks on channel 0.
        cfg_write(2'd0, 16'h7EE8, 16'h10B5);
        ch_en = 4'b0001;
        m_y1  = 16'sh10B5;
        m_y2  = '0;
        for (int n = 0; n < 8; n++) begin
            wait_tick(ok);
            step(4);
            m_exp = osc_model(16'sh7EE8, m_y1, m_y2);
            chk($sformatf("rec%0d_valid", n), out_valid, 1);
            chk($sformatf("rec%0d_data", n), out_data, m_exp);
            m_y2 = m_y1;
            m_y1 = m_exp;
        end
        ch_en = '0;
        step(2);
        chk("rec_no_sat", sat_flag, 0);

        // Multi-channel sweep with channel 2 skipped.
        cfg_write(2'd0, 16'h4000, 16'h2000);
        cfg_write(2'd1, 16'hC000, 16'h2000);
        cfg_write(2'd2, 16'h7EE8, 16'h10B5);
        cfg_write(2'd3, 16'h0000, 16'h1234);
        ch_en = 4'b1011;
        wait_tick(ok);
        step(1);
        chk("mc_cfg_ready_T1", cfg_ready, 0);
        step(3);
        chk("mc_T4_valid", out_valid, 1);
        chk("mc_T4_ch", out_ch, 0);
        chk("mc_T4_data", out_data, 16'h2000);
        step(1);
        chk("mc_T5_valid", out_valid, 0);
        step(3);
        chk("mc_T8_valid", out_valid, 1);
        chk("mc_T8_ch", out_ch, 1);
        chk("mc_T8_data", out_data, 16'hE000);
        step(4);
        chk("mc_T12_valid", out_valid, 1);
        chk("mc_T12_ch", out_ch, 3);
        chk("mc_T12_data", out_data, 16'h0000);
        step(1);
        chk("mc_T13_valid", out_valid, 0);
        chk("mc_T13_cfg_ready", cfg_ready, 1);
        ch_en = 4'b0100;
        wait_tick(ok);
        step(4);
        chk("mc_ch2_frozen_ch", out_ch, 2);
        chk("mc_ch2_frozen_data", out_data, 16'h2120);
        ch_en = '0;
        step(1);

        // Long stall: output hold, overrun, discarded config write.
        cfg_write(2'd0, 16'h7EE8, 16'h10B5);
        cfg_write(2'd1, 16'h4000, 16'h2000);
        ch_en     = 4'b0001;
        out_ready = 1'b0;
        wait_tick(ok);
        step(4);
        chk("stall_first_valid", out_valid, 1);
        chk("stall_first_data", out_data, 16'h2120);
        chk("stall_overrun_before", overrun, 0);
        ch_en = 4'b0010;
        cfg_write(2'd1, 16'h0000, 16'h0000);
        bad_cnt   = 0;
        seen_tick = 1'b0;
        for (int c = 0; c < 1999; c++) begin
            if (out_valid !== 1'b1 || out_data !== 16'h2120 || out_ch !== 2'd0) bad_cnt++;
            if (sample_tick) seen_tick = 1'b1;
            step(1);
        end
        chk("stall_hold_cycles", bad_cnt, 0);
        chk("stall_tick_seen", seen_tick, 1);
        chk("stall_overrun", overrun, 1);
        out_ready = 1'b1;
        step(1);
        chk("stall_release_valid", out_valid, 0);
        chk("stall_release_cfg_ready", cfg_ready, 1);
        wait_tick(ok);
        step(4);
        chk("stall_next_ch", out_ch, 1);
        chk("stall_cfg_discarded", out_data, 16'h2000);
        chk("stall_overrun_sticky", overrun, 1);
        ch_en = '0;
        step(1);

        // Saturation versus wrap, both directions.
        chk("sat_before", sat_flag, 0);
        cfg_write(2'd3, 16'h7FFF, 16'h7FFF);
        ch_en = 4'b1000;
        wait_tick(ok);
        step(4);
        chk("sat_pos_data", out_data, SAT ? 16'h7FFF : 16'hFFFC);
        chk("sat_pos_flag", sat_flag, SAT);
        step(1);
        cfg_write(2'd3, 16'h8000, 16'h7FFF);
        wait_tick(ok);
        step(4);
        chk("sat_neg_data", out_data, SAT ? 16'h8000 : 16'h0002);
        chk("sat_neg_flag", sat_flag, SAT);
        step(1);

        // Reset in MUL: immediate return to reset values, then zeroed channels.
        cfg_write(2'd0, 16'h4000, 16'h2000);
        ch_en = 4'b0001;
        wait_tick(ok);
        step(2);
        reset = 1'b1;
        #1;
        chk("mulrst_cfg_ready", cfg_ready, 1);
        chk("mulrst_out_valid", out_valid, 0);
        chk("mulrst_out_data", out_data, 0);
        chk("mulrst_overrun", overrun, 0);
        chk("mulrst_sat_flag", sat_flag, 0);
        chk("mulrst_sample_tick", sample_tick, 0);
        step(2);
        reset = 1'b0;
        wait_tick(ok);
        step(4);
        chk("mulrst_restart_valid", out_valid, 1);
        chk("mulrst_restart_ch", out_ch, 0);
        chk("mulrst_restart_data", out_data, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
